mux_byte_serializer: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the team's 8-to-1 mux datapath.
- Accepts one 8-bit byte per frame over a valid/ready handshake and registers it.
- Steps a 3-bit select counter through the byte and emits one bit per accepted output beat, with its own valid/ready handshake.
- Feeds serial links and the mux-based test harness.

---
 rtl/mux_ser_pkg.sv | 22 ++
 rtl/mux_byte_serializer_mux.sv | 19 +
 rtl/mux_byte_serializer.sv | 122 ++++++++++++
 tb/tb_mux_byte_serializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_ser_pkg.sv
// Shared types and sizes for the byte serializer and its bit-select mux.
package mux_ser_pkg;

  localparam int FRAME_BITS = 8;
  localparam int SEL_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Select value of the first and final data beat for a given bit order.
  function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
    return msb_first ? SEL_W'(FRAME_BITS - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_final(input bit msb_first);
    return msb_first ? '0 : SEL_W'(FRAME_BITS - 1);
  endfunction

endpackage

// File: rtl/mux_byte_serializer_mux.sv
// 8-to-1 bit-select datapath: picks input_lines[selector_bits].
module eightToOneMux
  import mux_ser_pkg::*;
(
  input  logic [FRAME_BITS-1:0] input_lines,
  input  logic [SEL_W-1:0]      selector_bits,
  output logic                  output_bit
);

  logic [FRAME_BITS-1:0] hit;

  // One-hot decode then OR-reduce, so each input line is an independent AND term.
  for (genvar i = 0; i < FRAME_BITS; i++) begin : g_line
    assign hit[i] = input_lines[i] & (selector_bits == SEL_W'(i));
  end

  assign output_bit = |hit;

endmodule

// File: rtl/mux_byte_serializer.sv
// Byte-to-bit serializer: valid/ready byte in, valid/ready bit stream out.
// Define MUX_SER_PARITY_EN to append an even-parity beat to every frame.
module mux_byte_serializer
  import mux_ser_pkg::*;
#(
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_data,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic [SEL_W-1:0]      ser_sel,
  output logic                  ser_last,
  output logic                  frame_done
);

`ifdef MUX_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [SEL_W-1:0] SEL_START = sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_END   = sel_final(MSB_FIRST);

  ser_state_t            state;
  logic [FRAME_BITS-1:0] data_reg;
  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      sel_next;
  logic                  mux_bit;

  assign sel_next = MSB_FIRST ? sel - 1'b1 : sel + 1'b1;
  assign ser_sel  = sel;

  eightToOneMux u_mux (
    .input_lines  (data_reg),
    .selector_bits(sel),
    .output_bit   (mux_bit)
  );

  always_comb begin
    ser_data = IDLE_LEVEL;
    case (state)
      SHIFT:   ser_data = mux_bit;
`ifdef MUX_SER_PARITY_EN
      PARITY:  ser_data = ^data_reg;
`endif
      default: ser_data = IDLE_LEVEL;
    endcase
  end

  // sel returns to 0 on leaving SHIFT so ser_sel reads 0 whenever no data beat is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_reg   <= '0;
      sel        <= '0;
      in_ready   <= 1'b1;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_reg  <= in_data;
            sel       <= SEL_START;
            state     <= SHIFT;
            in_ready  <= 1'b0;
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (sel == SEL_END) begin
              sel <= '0;
`ifdef MUX_SER_PARITY_EN
              state    <= PARITY;
              ser_last <= 1'b1;
`else
              state      <= IDLE;
              in_ready   <= 1'b1;
              ser_valid  <= 1'b0;
              ser_last   <= 1'b0;
              frame_done <= 1'b1;
`endif
            end else begin
              sel      <= sel_next;
              ser_last <= (sel_next == SEL_END) && !PAR_EN;
            end
          end
        end
`ifdef MUX_SER_PARITY_EN
        PARITY: begin
          if (ser_ready) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            ser_valid  <= 1'b0;
            ser_last   <= 1'b0;
            frame_done <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          sel       <= '0;
          in_ready  <= 1'b1;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_byte_serializer.sv
// Bench for mux_byte_serializer: LSB-first and MSB-first instances share stimulus.
// Honors MUX_SER_PARITY_EN for the expected frame length.
module tb_mux_byte_serializer;

`ifdef MUX_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            ser_ready;
  logic [1:0]      in_ready, ser_data, ser_valid, ser_last, frame_done;
  logic [1:0][2:0] ser_sel;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_byte_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready), .ser_sel(ser_sel[0]), .ser_last(ser_last[0]),
    .frame_done(frame_done[0])
  );

  mux_byte_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready), .ser_sel(ser_sel[1]), .ser_last(ser_last[1]),
    .frame_done(frame_done[1])
  );

  // Observed vector: {ser_valid, in_ready, ser_data, ser_sel[2:0], ser_last, frame_done}
  function automatic logic [7:0] obs(input int d);
    return {ser_valid[d], in_ready[d], ser_data[d], ser_sel[d], ser_last[d], frame_done[d]};
  endfunction

  // Beat k of a frame carrying byte b: data bits in the chosen order, then optional parity.
  function automatic logic [7:0] exp_beat(input logic [7:0] b, input int k, input int msb);
    int   idx;
    logic last;
    last = (k == NB - 1);
    if (k < 8) begin
      idx = (msb != 0) ? 7 - k : k;
      return {1'b1, 1'b0, b[idx], 3'(idx), last, 1'b0};
    end
    return {1'b1, 1'b0, ^b, 3'd0, 1'b1, 1'b0};
  endfunction

  function automatic logic [7:0] exp_idle(input logic done);
    return {1'b0, 1'b1, 1'b1, 3'd0, 1'b0, done};
  endfunction

  // Presents byte b, then follows the frame beat by beat. mode: 0 ready high,
  // 1 random ready, 2 ready low for 3 cycles at beat index 2.
  task automatic run_frame(input logic [7:0] b, input int mode, input string tag);
    int   k = 0;
    int   stalls = 0;
    logic rdy;
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    for (int c = 0; c < 200 && k < NB; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_beat(b, k, d)) begin
          n_fail++;
          $display("FAIL %s beat%0d dut%0d: got %b want %b", tag, k, d, obs(d), exp_beat(b, k, d));
        end
      end
      case (mode)
        0: ser_ready = 1'b1;
        1: ser_ready = 1'($urandom_range(0, 1));
        default: begin
          ser_ready = !(k == 2 && stalls < 3);
          if (!ser_ready) stalls++;
        end
      endcase
      rdy = ser_ready;
      @(posedge clk); #1;
      if (rdy) k++;
    end
    n_checks++;
    if (k < NB) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d beats want %0d", tag, k, NB);
    end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs(d) !== exp_idle(1'b1)) begin
        n_fail++;
        $display("FAIL %s done dut%0d: got %b want %b", tag, d, obs(d), exp_idle(1'b1));
      end
    end
  endtask

  task automatic idle_gap(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs(d) !== exp_idle(1'b0)) begin
          n_fail++;
          $display("FAIL %s idle dut%0d: got %b want %b", tag, d, obs(d), exp_idle(1'b0));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; ser_ready = 1'b0; in_data = 8'h00;
    #12;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs(d) !== exp_idle(1'b0)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %b want %b", d, obs(d), exp_idle(1'b0));
      end
    end
    @(negedge clk); rst = 1'b0;
    idle_gap(2, "post_reset");
  endtask

  task automatic test_lsb_a5();
    run_frame(8'hA5, 0, "a5");
    idle_gap(1, "a5");
  endtask

  task automatic test_msb_81();
    run_frame(8'h81, 0, "81");
    idle_gap(1, "81");
  endtask

  task automatic test_backpressure();
    run_frame(8'h3C, 2, "stall_3c");
    idle_gap(1, "stall_3c");
  endtask

  task automatic test_back_to_back();
    longint c1, c2;
    run_frame(8'hFF, 0, "b2b_ff");
    c1 = cyc;
    run_frame(8'h00, 0, "b2b_00");
    c2 = cyc;
    n_checks++;
    if (c2 - c1 != NB + 1) begin
      n_fail++;
      $display("FAIL b2b period: got %0d want %0d", c2 - c1, NB + 1);
    end
    idle_gap(1, "b2b");
  endtask

  task automatic test_rst_mid();
    in_data = 8'h5A; in_valid = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs(d) !== exp_beat(8'h5A, 3, d)) begin
        n_fail++;
        $display("FAIL rst_mid beat3 dut%0d: got %b want %b", d, obs(d), exp_beat(8'h5A, 3, d));
      end
    end
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs(d) !== exp_idle(1'b0)) begin
        n_fail++;
        $display("FAIL rst_mid async dut%0d: got %b want %b", d, obs(d), exp_idle(1'b0));
      end
    end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    idle_gap(3, "rst_mid_no_done");
    run_frame(8'h01, 0, "after_rst_01");
    idle_gap(1, "after_rst_01");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_frame(8'($urandom), 1, "rand");
      if ($urandom_range(0, 1) != 0) idle_gap($urandom_range(1, 3), "rand");
    end
    idle_gap(1, "rand_end");
  endtask

  initial begin
    test_reset();
    test_lsb_a5();
    test_msb_81();
    test_backpressure();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
